// File: rtl/serial_rcv_bit_timer_if.sv
// Handshake/bus bundle between the rx front end and the receive bit timer.
interface serial_rcv_bit_timer_if #(
    parameter int unsigned DIV_WIDTH  = 32,
    parameter int unsigned BITS_WIDTH = 4
);
    logic                  enable;
    logic                  start;
    logic                  rx_sync;
    logic [DIV_WIDTH-1:0]  baud_div;
    logic [BITS_WIDTH-1:0] frame_bits;
    logic                  shift_strobe;
    logic                  packet_done;
    logic                  false_start;
    logic                  cfg_err;
    logic                  busy;
    logic [BITS_WIDTH-1:0] bit_index;

    // Master drives control and configuration and observes timing outputs.
    modport master (
        output enable, start, rx_sync, baud_div, frame_bits,
        input  shift_strobe, packet_done, false_start, cfg_err, busy, bit_index
    );

    // Slave is the bit timer itself.
    modport slave (
        input  enable, start, rx_sync, baud_div, frame_bits,
        output shift_strobe, packet_done, false_start, cfg_err, busy, bit_index
    );
endinterface

// File: rtl/serial_rcv_bit_timer.sv
// Receive bit-timing controller: start-bit centre check plus mid-bit shift
// strobes for a per-frame latched divisor and frame length.
module serial_rcv_bit_timer #(
    parameter int unsigned DIV_WIDTH  = 32,
    parameter int unsigned BITS_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    serial_rcv_bit_timer_if.slave  bus
);

    localparam logic [DIV_WIDTH-1:0]  CNT_ONE = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0]  DIV_MIN = DIV_WIDTH'(2);
    localparam logic [BITS_WIDTH-1:0] IDX_ONE = BITS_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        START_HALF = 2'd1,
        BITS       = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [BITS_WIDTH-1:0] bits_q, bits_d;
    logic [BITS_WIDTH-1:0] idx_q, idx_d;
    logic                  shift_q, shift_d;
    logic                  done_q, done_d;
    logic                  fs_q, fs_d;
    logic                  cfg_pend_q, cfg_pend_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  busy_q, busy_d;

    logic                  accept;
    logic [DIV_WIDTH-1:0]  half_m1;
    logic [DIV_WIDTH-1:0]  div_m1;
    logic [BITS_WIDTH-1:0] idx_inc;

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            bits_q     <= '0;
            idx_q      <= '0;
            shift_q    <= 1'b0;
            done_q     <= 1'b0;
            fs_q       <= 1'b0;
            cfg_pend_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bits_q     <= bits_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            fs_q       <= fs_d;
            cfg_pend_q <= cfg_pend_d;
            cfg_err_q  <= cfg_err_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, counter and strobe decode; enable=0 overrides everything.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bits_d     = bits_q;
        idx_d      = idx_q;
        shift_d    = 1'b0;
        done_d     = 1'b0;
        fs_d       = 1'b0;
        cfg_pend_d = 1'b0;
        // cfg_err and busy trail acceptance/state by one cycle
        cfg_err_d  = cfg_pend_q;
        busy_d     = (state_q != IDLE);
        accept     = 1'b0;
        half_m1    = (div_q >> 1) - CNT_ONE;
        div_m1     = div_q - CNT_ONE;
        idx_inc    = idx_q + IDX_ONE;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
            end
            START_HALF: begin
                // bit_index from a back-to-back frame's last strobe clears here
                idx_d = '0;
                if (cnt_q == half_m1) begin
                    cnt_d = '0;
                    if (bus.rx_sync) begin
                        fs_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = BITS;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            BITS: begin
                if (cnt_q == div_m1) begin
                    cnt_d   = '0;
                    shift_d = 1'b1;
                    idx_d   = idx_inc;
                    if (idx_inc == bits_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Start is taken when idle or on the final strobe of a frame.
        accept = bus.enable && bus.start && ((state_q == IDLE) || done_d);
        if (accept) begin
            div_d  = bus.baud_div;
            bits_d = bus.frame_bits;
            cnt_d  = '0;
            if ((bus.baud_div < DIV_MIN) || (bus.frame_bits == '0)) begin
                cfg_pend_d = 1'b1;
                state_d    = IDLE;
            end else begin
                state_d = START_HALF;
            end
        end

        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = 1'b0;
            done_d  = 1'b0;
            fs_d    = 1'b0;
        end
    end

    assign bus.shift_strobe = shift_q;
    assign bus.packet_done  = done_q;
    assign bus.false_start  = fs_q;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.busy         = busy_q;
    assign bus.bit_index    = idx_q;

endmodule

// File: tb/tb_serial_rcv_bit_timer.sv
// Bench for serial_rcv_bit_timer: directed frames then random stimulus, all
// checked cycle by cycle against a frame-timing model built from t0/H/D/N.
module tb_serial_rcv_bit_timer;

    logic clk;
    logic n_rst;

    serial_rcv_bit_timer_if #(.DIV_WIDTH(32), .BITS_WIDTH(4)) bus ();

    serial_rcv_bit_timer #(.DIV_WIDTH(32), .BITS_WIDTH(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: a frame is "accepted at edge t0 with D, N".
    longint now;
    bit     m_in_frame;
    bit     m_cfg_pend;
    longint m_t0, m_d, m_n, m_idx;
    bit     exp_ss, exp_pd, exp_fs, exp_cfg, exp_busy;
    longint exp_idx;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, now, got, exp);
        end
    endtask

    task automatic model_reset();
        now        = 0;
        m_in_frame = 0;
        m_cfg_pend = 0;
        m_t0       = 0;
        m_d        = 0;
        m_n        = 0;
        m_idx      = 0;
    endtask

    // Predict the outputs registered at the coming edge from current inputs.
    task automatic model_step();
        longint rel, h, k;
        exp_busy   = m_in_frame;
        exp_cfg    = m_cfg_pend;
        m_cfg_pend = 0;
        exp_ss     = 0;
        exp_pd     = 0;
        exp_fs     = 0;
        if (bus.enable) begin
            if (m_in_frame) begin
                rel = now - m_t0;
                h   = m_d / 2;
                if (rel <= h) m_idx = 0;
                if (rel == h) begin
                    if (bus.rx_sync) begin
                        exp_fs     = 1;
                        m_in_frame = 0;
                    end
                end else if (rel > h && ((rel - h) % m_d) == 0) begin
                    k      = (rel - h) / m_d;
                    exp_ss = 1;
                    m_idx  = k;
                    if (k == m_n) begin
                        exp_pd     = 1;
                        m_in_frame = 0;
                    end
                end
            end else begin
                m_idx = 0;
            end
            if (bus.start && (!exp_busy || exp_pd)) begin
                m_d = longint'(bus.baud_div);
                m_n = longint'(bus.frame_bits);
                if (m_d < 2 || m_n == 0) begin
                    m_cfg_pend = 1;
                end else begin
                    m_in_frame = 1;
                    m_t0       = now;
                end
            end
        end else begin
            m_in_frame = 0;
            m_idx      = 0;
        end
        exp_idx = m_idx;
        now++;
    endtask

    task automatic check_outputs();
        check_val("shift_strobe", bus.shift_strobe, exp_ss);
        check_val("packet_done",  bus.packet_done,  exp_pd);
        check_val("false_start",  bus.false_start,  exp_fs);
        check_val("cfg_err",      bus.cfg_err,      exp_cfg);
        check_val("busy",         bus.busy,         exp_busy);
        check_val("bit_index",    bus.bit_index,    exp_idx);
    endtask

    // One clock: predict, clock, sample 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_shift"}, bus.shift_strobe, 1'b0);
        check_val({tag, "_done"},  bus.packet_done,  1'b0);
        check_val({tag, "_fs"},    bus.false_start,  1'b0);
        check_val({tag, "_cfg"},   bus.cfg_err,      1'b0);
        check_val({tag, "_busy"},  bus.busy,         1'b0);
        check_val({tag, "_idx"},   bus.bit_index,    4'd0);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        #1;
        check_all_zero("reset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        bus.enable     = 1'b0;
        bus.start      = 1'b0;
        bus.rx_sync    = 1'b0;
        bus.baud_div   = 32'd0;
        bus.frame_bits = 4'd0;
        n_rst          = 1'b1;
        #2;
        do_reset();

        // Nominal 9-bit frame, D=286.
        bus.enable     = 1'b1;
        bus.baud_div   = 32'd286;
        bus.frame_bits = 4'd9;
        pulse_start();
        repeat (2800) tick();

        // False start: line high at start-bit centre.
        bus.rx_sync = 1'b1;
        pulse_start();
        repeat (200) tick();
        bus.rx_sync = 1'b0;

        // Enable dropped mid-frame, then an immediate new start.
        pulse_start();
        repeat (999) tick();
        bus.enable = 1'b0;
        tick();
        bus.enable = 1'b1;
        pulse_start();
        repeat (2800) tick();

        // Minimum legal config with a back-to-back start.
        bus.baud_div   = 32'd2;
        bus.frame_bits = 4'd1;
        pulse_start();
        repeat (2) tick();
        pulse_start();
        repeat (6) tick();

        // Illegal configs.
        bus.baud_div = 32'd1;
        pulse_start();
        repeat (3) tick();
        bus.baud_div   = 32'd2;
        bus.frame_bits = 4'd0;
        pulse_start();
        repeat (3) tick();

        // Divisor change mid-frame must be ignored.
        bus.baud_div   = 32'd10;
        bus.frame_bits = 4'd8;
        pulse_start();
        repeat (19) tick();
        bus.baud_div = 32'd50;
        repeat (100) tick();

        // Asynchronous reset mid-frame.
        bus.baud_div   = 32'd286;
        bus.frame_bits = 4'd9;
        pulse_start();
        repeat (499) tick();
        #2;
        bus.start = 1'b1;
        do_reset();
        bus.start = 1'b0;
        repeat (5) tick();

        // Random traffic.
        for (int i = 0; i < 15000; i++) begin
            bus.enable  = ($urandom_range(0, 299) != 0);
            bus.start   = ($urandom_range(0, 15) == 0);
            bus.rx_sync = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.baud_div   = 32'($urandom_range(0, 12));
                bus.frame_bits = 4'($urandom_range(0, 15));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
